// File: rtl/mips_pkg.sv
// Shared constants for the pipelined MIPS core.
// This package defines the PC width, the reset/vector addresses and the NOP encoding.
package mips_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] RESET_PC = 32'h8000_0000;
    localparam logic [PC_W-1:0] IRQ_VEC  = 32'h8000_0004;
    localparam logic [PC_W-1:0] EXC_VEC  = 32'h8000_0008;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for the asynchronous timer interrupt request.
// It is used only when FETCH_IRQ_SYNC_EN is defined.
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;

    // Shift the request through two flops; both clear on reset so no stale request survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage of the pipelined MIPS core: PC register, next-PC select, IF/ID register and EPC capture.
// When the macro FETCH_IRQ_SYNC_EN is defined, irq passes through a 2-flop synchronizer
// (irq_sync) before it is used. Otherwise irq is used directly.
module fetch_stage
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [31:0]     inst_in,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            exc,
    input  logic            irq,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     if_id_inst,
    output logic [PC_W-1:0] if_id_pc_plus4,
    output logic            if_id_valid,
    output logic [PC_W-1:0] epc,
    output logic            epc_we,
    output logic [31:0]     fetch_count
);

    logic            irq_eff;
    logic            irq_accept;
    logic            redirect;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] epc_next;

`ifdef FETCH_IRQ_SYNC_EN
    irq_sync u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .din   (irq),
        .dout  (irq_eff)
    );
`else
    assign irq_eff = irq;
`endif

    assign pc_plus4   = pc + 32'd4;
    assign irq_accept = irq_eff && !pc[31] && !exc;
    assign redirect   = exc || irq_accept || branch_taken || jr || jump;

    // Next-PC priority mux and the EPC candidate (a control redirect target, else the squashed fetch pc).
    always_comb begin
        next_pc  = pc_plus4;
        epc_next = pc;
        if (branch_taken) begin
            epc_next = branch_target;
        end else if (jr) begin
            epc_next = jr_target;
        end else if (jump) begin
            epc_next = jump_target;
        end

        if (exc) begin
            next_pc = EXC_VEC;
        end else if (irq_accept) begin
            next_pc = IRQ_VEC;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (stall) begin
            next_pc = pc;
        end
    end

    // PC register: redirects override a stall because the redirecting instruction is older.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // IF/ID register: flush on a redirect, hold on a stall, otherwise capture the ROM word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_inst     <= NOP;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            fetch_count    <= '0;
        end else if (redirect) begin
            if_id_inst     <= NOP;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            if_id_inst     <= inst_in;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            fetch_count    <= fetch_count + 32'd1;
        end
    end

    // EPC capture on interrupt acceptance, with a one-cycle write pulse toward $26.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc    <= '0;
            epc_we <= 1'b0;
        end else begin
            epc_we <= irq_accept;
            if (irq_accept) begin
                epc <= epc_next;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed vector table plus hand-written interrupt sequences.
// The interrupt sequences follow FETCH_IRQ_SYNC_EN when it is defined.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] inst_in;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exc;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] epc;
    logic        epc_we;
    logic [31:0] fetch_count;

    int num_checks;
    int num_fails;

    typedef struct {
        logic        stall;
        logic        jump;
        logic        jr;
        logic        br;
        logic [31:0] jump_t;
        logic [31:0] jr_t;
        logic [31:0] br_t;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc4;
        logic        exp_valid;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[13];

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .inst_in        (inst_in),
        .jump           (jump),
        .jump_target    (jump_target),
        .jr             (jr),
        .jr_target      (jr_target),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .exc            (exc),
        .irq            (irq),
        .pc             (pc),
        .if_id_inst     (if_id_inst),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .epc            (epc),
        .epc_we         (epc_we),
        .fetch_count    (fetch_count)
    );

    // ROM model: each word holds its own word index.
    assign inst_in = {2'b00, pc[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; jump = 0; jr = 0; branch_taken = 0; exc = 0; irq = 0;
        jump_target = 0; jr_target = 0; branch_target = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        stall = v.stall; jump = v.jump; jr = v.jr; branch_taken = v.br;
        jump_target = v.jump_t; jr_target = v.jr_t; branch_target = v.br_t;
        exc = 0; irq = 0;
        step();
    endtask

    task automatic check_output(input int i, input vec_t v);
        check32($sformatf("row%0d pc", i), pc, v.exp_pc);
        check32($sformatf("row%0d inst", i), if_id_inst, v.exp_inst);
        check32($sformatf("row%0d pc4", i), if_id_pc_plus4, v.exp_pc4);
        check32($sformatf("row%0d valid", i), {31'b0, if_id_valid}, {31'b0, v.exp_valid});
        check32($sformatf("row%0d count", i), fetch_count, v.exp_cnt);
        check32($sformatf("row%0d epc_we", i), {31'b0, epc_we}, 32'd0);
    endtask

    initial begin
        num_checks = 0;
        num_fails  = 0;
        clear_inputs();

        //           stall jmp jr  br  jump_t        jr_t          br_t          pc            inst          pc4           v  cnt
        vecs[0]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h8000_0004, 32'h2000_0000, 32'h8000_0004, 1, 1};
        vecs[1]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h8000_0008, 32'h2000_0001, 32'h8000_0008, 1, 2};
        vecs[2]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h8000_000C, 32'h2000_0002, 32'h8000_000C, 1, 3};
        vecs[3]  = '{1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h8000_000C, 32'h2000_0002, 32'h8000_000C, 1, 3};
        vecs[4]  = '{1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h8000_000C, 32'h2000_0002, 32'h8000_000C, 1, 3};
        vecs[5]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h8000_0010, 32'h2000_0003, 32'h8000_0010, 1, 4};
        vecs[6]  = '{1, 1, 0, 1, 32'h0000_0999, 32'h0,         32'h8000_0040, 32'h8000_0040, 32'h0,         32'h0,         0, 4};
        vecs[7]  = '{0, 0, 1, 0, 32'h0,         32'h0000_0100, 32'h0,         32'h0000_0100, 32'h0,         32'h0,         0, 4};
        vecs[8]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0104, 32'h0000_0040, 32'h0000_0104, 1, 5};
        vecs[9]  = '{0, 1, 1, 0, 32'h0000_0300, 32'h0000_0100, 32'h0,         32'h0000_0100, 32'h0,         32'h0,         0, 5};
        vecs[10] = '{0, 0, 1, 0, 32'h0,         32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 32'h0,         32'h0,         0, 5};
        vecs[11] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0000, 32'h3FFF_FFFF, 32'h0000_0000, 1, 6};
        vecs[12] = '{0, 0, 1, 0, 32'h0,         32'h0000_0100, 32'h0,         32'h0000_0100, 32'h0,         32'h0,         0, 6};

        reset = 1'b1;
        #2 reset = 1'b0;
        #5;
        check32("reset pc", pc, 32'h8000_0000);
        check32("reset inst", if_id_inst, 32'h0);
        check32("reset pc4", if_id_pc_plus4, 32'h0);
        check32("reset valid", {31'b0, if_id_valid}, 32'h0);
        check32("reset epc", epc, 32'h0);
        check32("reset epc_we", {31'b0, epc_we}, 32'h0);
        check32("reset count", fetch_count, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i]);
            check_output(i, vecs[i]);
        end
        clear_inputs();

`ifndef FETCH_IRQ_SYNC_EN
        // pc = 0x100, user mode: interrupt accepted on the first edge.
        irq = 1;
        step();
        check32("irq pc", pc, 32'h8000_0004);
        check32("irq epc_we", {31'b0, epc_we}, 32'h1);
        check32("irq epc", epc, 32'h0000_0100);
        check32("irq valid", {31'b0, if_id_valid}, 32'h0);
        step();
        check32("irq kernel pc", pc, 32'h8000_0008);
        check32("irq pulse end", {31'b0, epc_we}, 32'h0);
        check32("irq epc hold", epc, 32'h0000_0100);
        check32("irq count", fetch_count, 32'd7);
        step();
        check32("irq no nest pc", pc, 32'h8000_000C);
        check32("irq no nest we", {31'b0, epc_we}, 32'h0);

        // Leave handler to 0x200, then irq together with a jump.
        irq = 0; jr = 1; jr_target = 32'h0000_0200;
        step();
        check32("jr 200 pc", pc, 32'h0000_0200);
        jr = 0; irq = 1; jump = 1; jump_target = 32'h0000_0300;
        step();
        check32("irq+jump pc", pc, 32'h8000_0004);
        check32("irq+jump epc", epc, 32'h0000_0300);
        check32("irq+jump we", {31'b0, epc_we}, 32'h1);

        // Back to user mode, then exception together with irq.
        clear_inputs();
        jr = 1; jr_target = 32'h0000_0400;
        step();
        check32("jr 400 pc", pc, 32'h0000_0400);
        jr = 0; exc = 1; irq = 1;
        step();
        check32("exc pc", pc, 32'h8000_0008);
        check32("exc epc_we", {31'b0, epc_we}, 32'h0);
        check32("exc epc hold", epc, 32'h0000_0300);
        check32("exc valid", {31'b0, if_id_valid}, 32'h0);
        clear_inputs();
`else
        // Synchronized irq: rises at pc = 0, accepted on the third edge.
        jr = 1; jr_target = 32'h0000_0000;
        step();
        check32("sync jr pc", pc, 32'h0000_0000);
        jr = 0; irq = 1;
        step();
        check32("sync e1 pc", pc, 32'h0000_0004);
        check32("sync e1 we", {31'b0, epc_we}, 32'h0);
        step();
        check32("sync e2 pc", pc, 32'h0000_0008);
        check32("sync e2 we", {31'b0, epc_we}, 32'h0);
        step();
        check32("sync e3 pc", pc, 32'h8000_0004);
        check32("sync e3 we", {31'b0, epc_we}, 32'h1);
        check32("sync e3 epc", epc, 32'h0000_0008);
        clear_inputs();
`endif

        // Reset in mid-operation returns everything immediately.
        step();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check32("midreset pc", pc, 32'h8000_0000);
        check32("midreset count", fetch_count, 32'h0);
        check32("midreset epc", epc, 32'h0);
        check32("midreset valid", {31'b0, if_id_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register and IF/ID pipeline register of the pipelined MIPS core; sits directly upstream of the instruction ROM.
- Drives the ROM address from `pc`, captures the returned instruction into IF/ID, and selects the next PC.
- Next-PC sources: sequential, jump, jr, branch, interrupt vector and exception vector.
- On interrupt acceptance, produces the EPC value the register file writes to $26.

Parameters:
RESET_PC, 32'h8000_0000, PC after reset (supervisor bit 31 set, word 0 = `j main`)
IRQ_VEC, 32'h8000_0004, interrupt handler entry
EXC_VEC, 32'h8000_0008, exception handler entry

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  load-use hazard: hold PC and IF/ID
inst_in  in  32  instruction returned combinationally by the ROM for `pc`
jump  in  1  j/jal decoded in ID
jump_target  in  32  {pc_plus4_id[31:28], imm26, 2'b00}
jr  in  1  jr/jalr decoded in ID
jr_target  in  32  forwarded rs value
branch_taken  in  1  branch resolved taken in EX
branch_target  in  32  EX branch target
exc  in  1  undefined-instruction exception from ID
irq  in  1  timer interrupt request, level
pc  out  32  current fetch address to the ROM
if_id_inst  out  32  IF/ID instruction
if_id_pc_plus4  out  32  IF/ID PC+4
if_id_valid  out  1  IF/ID holds a real instruction
epc  out  32  return address for $26
epc_we  out  1  one-cycle pulse: write `epc` into $26
fetch_count  out  32  count of valid IF/ID loads

Behaviour:
- Reset (reset==0, async) values:
  - pc=RESET_PC
  - if_id_inst=0 (NOP), if_id_pc_plus4=0, if_id_valid=0
  - epc=0, epc_we=0, fetch_count=0
- Latency: ROM is combinational, so `inst_in` is sampled on the same edge that advances `pc`. IF to ID is 1 cycle.
- Next-PC priority, highest first:
  - exc: pc=EXC_VEC
  - irq accepted: pc=IRQ_VEC
  - branch_taken: pc=branch_target
  - jr: pc=jr_target
  - jump: pc=jump_target
  - stall: pc held
  - otherwise: pc=pc+4
- Redirects (exc, irq, branch, jr, jump) override stall, because the redirecting instruction is older than the stalled one.
- Flush: on any redirect, IF/ID is loaded with NOP, if_id_valid=0 and pc_plus4=0. The mis-fetched instruction is discarded.
- Stall without redirect: IF/ID holds its contents; fetch_count does not increment.
- Normal cycle: if_id_inst=inst_in, if_id_pc_plus4=pc+4, if_id_valid=1, fetch_count+1.
- pc+4 arithmetic wraps modulo 2^32. fetch_count wraps 0xFFFF_FFFF -> 0.
- IRQ acceptance:
  - Conditions: irq_eff==1 (see Optional Feature) AND pc[31]==0 (user mode) AND exc==0.
  - While pc[31]==1 (kernel / handler), irq is ignored; no nesting.
  - The handler leaves through `jr $26`, which clears bit 31.
- EPC:
  - On acceptance, epc = the address that would otherwise have been fetched next, which is the squashed IF pc.
  - If branch_taken/jr/jump is also active that cycle, epc = that redirect target instead.
  - epc_we pulses 1 for exactly one cycle, the cycle after acceptance. epc holds its value until the next acceptance.
- Exception: epc is not written; the handler does not return.
- Reset mid-operation: all state returns to reset values immediately; no pending irq is remembered.

Optional Feature:
- Macro: FETCH_IRQ_SYNC_EN.
- Defined:
  - irq passes through a 2-flop synchronizer (both flops reset to 0) before use.
  - irq_eff = synchronized irq; 2 extra cycles from irq rise to acceptance.
- Undefined:
  - irq_eff = irq directly; acceptance is possible on the first edge where irq==1.

Decomposition:
- Shared package `mips_pkg`:
  - localparams RESET_PC, IRQ_VEC, EXC_VEC
  - NOP encoding 32'h0000_0000
  - PC width 32
- One sub-module, `irq_sync`: the 2-flop synchronizer, instantiated only under FETCH_IRQ_SYNC_EN.
- Next-PC mux stays inline.

Test Plan:
- Reset release, no hazards, inst_in = word index:
  - pc = 0x80000000, then 0x80000004 and 0x80000008 on consecutive edges.
  - if_id_pc_plus4 = 0x80000004 one cycle after the first edge.
  - fetch_count = 3 after 3 edges.
- stall=1 for 2 cycles at pc=0x8000000C:
  - pc and IF/ID frozen 2 cycles, fetch_count unchanged.
  - Then resumes at 0x80000010.
- branch_taken=1, target 0x80000040, together with stall=1 and jump=1:
  - next pc = 0x80000040, if_id_valid=0, if_id_inst=0.
- pc=0x00000100, irq=1, no redirect:
  - next pc = 0x80000004.
  - epc_we pulses the following cycle with epc=0x00000100.
  - irq held at 1 while pc[31]=1 does not re-trigger.
- pc=0x00000200, irq=1 and jump_target=0x00000300:
  - pc = 0x80000004, epc = 0x00000300.
- exc=1 together with irq=1:
  - pc = 0x80000008, epc_we stays 0.
- With FETCH_IRQ_SYNC_EN, irq rises at pc=0x00000000:
  - accepted on the 3rd edge (pc = 0x00000008 is squashed), epc = 0x00000008.
